dot_product_feeder: RTL and testbench

Upstream stage of the long vector dot-product accumulator. It accepts 8-lane int8 data/weight vector beats over a valid/ready stream with a frame-last marker and buffers them in a small FIFO. It drives the accumulator's level-sensitive compute/t_data/weights interface, so that each frame yields exactly one compute-high window followed by a compute-low gap. It then waits for the accumulator's out_valid before starting the next frame.

---
 rtl/dot_product_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/dot_product_feeder.sv | 125 ++++++++++++
 tb/tb_dot_product_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared types for the dot-product feeder: lane geometry, vector and beat formats,
// and the feeder FSM state encoding.
package dot_product_pkg;

    localparam int LANES  = 8;
    localparam int ELEM_W = 8;

    typedef logic [LANES-1:0][ELEM_W-1:0] vec_t;

    // One buffered upstream beat, 129 bits.
    typedef struct packed {
        logic last;
        vec_t weights;
        vec_t data;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP,
        WAIT_RES
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. Full and empty are derived only from the
// pointer registers, so a same-cycle pop never lifts full.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; clearing the pointers already makes every entry invisible.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dot_product_feeder.sv
// Feeds buffered data/weight beats to the dot-product accumulator as one compute-high
// window per frame, pads FIFO underflow with zero vectors, then waits for the result.
module dot_product_feeder
    import dot_product_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [LANES-1:0][ELEM_W-1:0] s_t_data,
    input  logic [LANES-1:0][ELEM_W-1:0] s_weights,
    input  logic                         s_last,
    output logic                         m_compute,
    output logic [LANES-1:0][ELEM_W-1:0] m_t_data,
    output logic [LANES-1:0][ELEM_W-1:0] m_weights,
    input  logic                         m_out_valid,
    output logic                         busy,
    output logic [CNT_W-1:0]             frame_beats,
    output logic [CNT_W-1:0]             bubble_cnt
);

    state_t           state;
    state_t           state_nxt;
    beat_t            push_beat;
    beat_t            head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             compute_nxt;
    vec_t             data_nxt;
    vec_t             wts_nxt;
    logic [CNT_W-1:0] beats_nxt;
    logic [CNT_W-1:0] bubbles_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign push_beat = '{last: s_last, weights: s_weights, data: s_t_data};
    assign s_ready   = !fifo_full;
    assign busy      = (state != IDLE);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (s_valid),
        .wr_data (push_beat),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_compute   <= 1'b0;
            m_t_data    <= '0;
            m_weights   <= '0;
            frame_beats <= '0;
            bubble_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            m_compute   <= compute_nxt;
            m_t_data    <= data_nxt;
            m_weights   <= wts_nxt;
            frame_beats <= beats_nxt;
            bubble_cnt  <= bubbles_nxt;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt   = state;
        fifo_pop    = 1'b0;
        compute_nxt = 1'b0;
        data_nxt    = '0;
        wts_nxt     = '0;
        beats_nxt   = frame_beats;
        bubbles_nxt = bubble_cnt;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    compute_nxt = 1'b1;
                    data_nxt    = head.data;
                    wts_nxt     = head.weights;
                    beats_nxt   = CNT_W'(1);
                    bubbles_nxt = '0;
                    state_nxt   = head.last ? GAP : STREAM;
                end
            end
            STREAM: begin
                compute_nxt = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    data_nxt  = head.data;
                    wts_nxt   = head.weights;
                    beats_nxt = sat_inc(frame_beats);
                    state_nxt = head.last ? GAP : STREAM;
                end else begin
                    // Zero lanes keep the window open without changing the sum.
                    bubbles_nxt = sat_inc(bubble_cnt);
                end
            end
            GAP: begin
                state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (m_out_valid) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dot_product_feeder.sv
// Directed bench for dot_product_feeder; CNT_W=2 so counter saturation is reachable.
module tb_dot_product_feeder;
    import dot_product_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    vec_t             s_t_data;
    vec_t             s_weights;
    logic             s_last;
    logic             m_compute;
    vec_t             m_t_data;
    vec_t             m_weights;
    logic             m_out_valid;
    logic             busy;
    logic [CNT_W-1:0] frame_beats;
    logic [CNT_W-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    dot_product_feeder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_t_data    (s_t_data),
        .s_weights   (s_weights),
        .s_last      (s_last),
        .m_compute   (m_compute),
        .m_t_data    (m_t_data),
        .m_weights   (m_weights),
        .m_out_valid (m_out_valid),
        .busy        (busy),
        .frame_beats (frame_beats),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, 64'(obs), 64'(exp));
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs, input int exp);
        logic [CNT_W-1:0] e;
        e = (exp > (2**CNT_W - 1)) ? CNT_W'(2**CNT_W - 1) : CNT_W'(exp);
        check(tag, 64'(obs), 64'(e));
    endtask

    task automatic check_out(input string tag, input logic comp, input vec_t d, input vec_t w);
        check_bit({tag, "_compute"}, m_compute, comp);
        check({tag, "_data"}, m_t_data, d);
        check({tag, "_weights"}, m_weights, w);
    endtask

    function automatic vec_t mk(input int base);
        vec_t v;
        for (int j = 0; j < LANES; j++) v[j] = ELEM_W'(base + j);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int base, input logic last);
        s_valid   = 1'b1;
        s_t_data  = mk(base);
        s_weights = mk(base + 8'h80);
        s_last    = last;
    endtask

    task automatic idle_in();
        s_valid   = 1'b0;
        s_t_data  = '0;
        s_weights = '0;
        s_last    = 1'b0;
    endtask

    task automatic pulse_out_valid();
        m_out_valid = 1'b1;
        tick();
        m_out_valid = 1'b0;
    endtask

    vec_t ones;

    initial begin
        ones        = {LANES{ELEM_W'(1)}};
        rst_n       = 1'b0;
        m_out_valid = 1'b0;
        idle_in();
        tick();
        tick();
        check_out("rst", 1'b0, '0, '0);
        check_bit("rst_busy", busy, 1'b0);
        check_cnt("rst_beats", frame_beats, 0);
        check_cnt("rst_bubbles", bubble_cnt, 0);
        rst_n = 1'b1;
        tick();
        check_bit("rst_ready", s_ready, 1'b1);
        check_bit("rst_busy_rel", busy, 1'b0);

        // Test 1: single-beat frame, lanes all 1
        s_valid = 1'b1; s_t_data = ones; s_weights = ones; s_last = 1'b1;
        tick();
        idle_in();
        check_bit("t1_not_yet", m_compute, 1'b0);
        tick();
        check_out("t1_beat", 1'b1, ones, ones);
        check_cnt("t1_beats", frame_beats, 1);
        check_cnt("t1_bubbles", bubble_cnt, 0);
        check_bit("t1_busy", busy, 1'b1);
        tick();
        check_out("t1_gap", 1'b0, '0, '0);
        check_bit("t1_wait_busy", busy, 1'b1);

        // Test 2: fill the FIFO while waiting; the out_valid pulse rides on the 4th push
        for (int k = 0; k < 4; k++) begin
            drive(16 * (k + 1), k == 3);
            m_out_valid = (k == 3);
            tick();
            check_bit("t2_fill_compute", m_compute, 1'b0);
            check_bit("t2_fill_ready", s_ready, k != 3);
        end
        idle_in();
        m_out_valid = 1'b0;
        check_bit("t2_idle", busy, 1'b0);
        check_cnt("t2_beats_held", frame_beats, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out("t2_beat", 1'b1, mk(16 * (k + 1)), mk(16 * (k + 1) + 8'h80));
            check_cnt("t2_beats", frame_beats, k + 1);
            check_bit("t2_ready", s_ready, 1'b1);
        end
        tick();
        check_out("t2_gap", 1'b0, '0, '0);
        check_bit("t2_gap_busy", busy, 1'b1);
        check_cnt("t2_bubbles", bubble_cnt, 0);
        pulse_out_valid();
        check_bit("t2_done", busy, 1'b0);

        // Test 3: underflow padded with three zero-vector cycles
        drive(8'h40, 1'b0);
        tick();
        check_bit("t3_first", m_compute, 1'b0);
        drive(8'h50, 1'b0);
        tick();
        idle_in();
        check_out("t3_b0", 1'b1, mk(8'h40), mk(8'h40 + 8'h80));
        tick();
        check_out("t3_b1", 1'b1, mk(8'h50), mk(8'h50 + 8'h80));
        check_cnt("t3_beats2", frame_beats, 2);
        tick();
        check_out("t3_bub1", 1'b1, '0, '0);
        check_cnt("t3_bubbles1", bubble_cnt, 1);
        tick();
        check_out("t3_bub2", 1'b1, '0, '0);
        drive(8'h60, 1'b1);
        tick();
        idle_in();
        check_out("t3_bub3", 1'b1, '0, '0);
        tick();
        check_out("t3_b2", 1'b1, mk(8'h60), mk(8'h60 + 8'h80));
        check_cnt("t3_beats", frame_beats, 3);
        check_cnt("t3_bubbles", bubble_cnt, 3);
        tick();
        check_out("t3_gap", 1'b0, '0, '0);
        pulse_out_valid();
        check_bit("t3_done", busy, 1'b0);

        // Test 4: 2-beat and 3-beat frames pushed back-to-back
        drive(8'h01, 1'b0); tick();
        check_bit("t4_c_lat", m_compute, 1'b0);
        drive(8'h11, 1'b1); tick();
        check_out("t4_c0", 1'b1, mk(8'h01), mk(8'h81));
        drive(8'h21, 1'b0); tick();
        check_out("t4_c1", 1'b1, mk(8'h11), mk(8'h91));
        drive(8'h31, 1'b0); tick();
        check_bit("t4_low1", m_compute, 1'b0);
        drive(8'h41, 1'b1); tick();
        idle_in();
        check_bit("t4_low2", m_compute, 1'b0);
        tick();
        check_bit("t4_low3", m_compute, 1'b0);
        check_bit("t4_wait", busy, 1'b1);
        pulse_out_valid();
        check_bit("t4_low4", m_compute, 1'b0);
        check_bit("t4_idle", busy, 1'b0);
        tick();
        check_out("t4_d0", 1'b1, mk(8'h21), mk(8'hA1));
        check_cnt("t4_beats1", frame_beats, 1);
        tick();
        check_out("t4_d1", 1'b1, mk(8'h31), mk(8'hB1));
        tick();
        check_out("t4_d2", 1'b1, mk(8'h41), mk(8'hC1));
        check_cnt("t4_beats", frame_beats, 3);
        tick();
        check_out("t4_gap", 1'b0, '0, '0);
        pulse_out_valid();
        check_bit("t4_done", busy, 1'b0);

        // Test 6: out_valid ignored in IDLE, STREAM and GAP
        pulse_out_valid();
        check_bit("t6_idle_busy", busy, 1'b0);
        check_bit("t6_idle_compute", m_compute, 1'b0);
        drive(8'h05, 1'b0); tick();
        idle_in(); tick();
        check_out("t6_e0", 1'b1, mk(8'h05), mk(8'h85));
        m_out_valid = 1'b1; tick();
        m_out_valid = 1'b0;
        check_out("t6_stream_bub", 1'b1, '0, '0);
        check_bit("t6_stream_busy", busy, 1'b1);
        drive(8'h15, 1'b1); tick();
        idle_in();
        check_out("t6_bub2", 1'b1, '0, '0);
        tick();
        check_out("t6_e1", 1'b1, mk(8'h15), mk(8'h95));
        m_out_valid = 1'b1; tick();
        m_out_valid = 1'b0;
        check_bit("t6_gap_compute", m_compute, 1'b0);
        tick();
        check_bit("t6_still_wait", busy, 1'b1);
        check_cnt("t6_beats", frame_beats, 2);
        check_cnt("t6_bubbles", bubble_cnt, 2);
        pulse_out_valid();
        check_bit("t6_done", busy, 1'b0);

        // Test 5: asynchronous reset during the second STREAM cycle
        drive(8'h0A, 1'b0); tick();
        drive(8'h1A, 1'b0); tick();
        check_out("t5_f0", 1'b1, mk(8'h0A), mk(8'h8A));
        drive(8'h2A, 1'b1); tick();
        idle_in();
        check_out("t5_f1", 1'b1, mk(8'h1A), mk(8'h9A));
        #1 rst_n = 1'b0;
        #1;
        check_out("t5_rst", 1'b0, '0, '0);
        check_bit("t5_rst_busy", busy, 1'b0);
        check_cnt("t5_rst_beats", frame_beats, 0);
        check_cnt("t5_rst_bubbles", bubble_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_bit("t5_ready", s_ready, 1'b1);
        check_bit("t5_busy", busy, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bit("t5_no_stale", m_compute, 1'b0);
            check_bit("t5_idle", busy, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
